// File: rtl/instruction_fetch_stage_pkg.sv
// rtl/instruction_fetch_stage_pkg.sv - shared fetch constants, select codes and PC increment helper
// Purpose: vectors, NOP encoding and next-PC select codes shared by the IF stage,
//          the ID stage and the exception controller.
// Ports:   none (package).
package instruction_fetch_stage_pkg;

  localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] DEF_IRQ_VEC   = 32'h8000_0004;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0008;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

  // Which source won the next-PC priority mux this cycle.
  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_HOLD = 3'd1,
    SEL_IRQ  = 3'd2,
    SEL_JUMP = 3'd3,
    SEL_JR   = 3'd4,
    SEL_BR   = 3'd5,
    SEL_EXC  = 3'd6
  } npc_sel_e;

  // Bit 31 is the kernel-mode flag and is never touched by the increment,
  // so user code at 7FFF_FFFC wraps to 0000_0000 instead of entering kernel space.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// rtl/instruction_fetch_stage_if.sv - instruction memory bus and IF/ID latch outputs
// Purpose: groups the instruction-memory address/data pair and the IF/ID latch
//          fields handed to the ID stage.
// Ports:   master = fetch stage (drives imem_addr and ifid_*, reads imem_instr)
//          slave  = memory / ID side (opposite directions)
interface instruction_fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_irq;
  logic        ifid_valid;

  modport master (
    output imem_addr,
    input  imem_instr,
    output ifid_instr,
    output ifid_pc,
    output ifid_pc_plus4,
    output ifid_irq,
    output ifid_valid
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    input  ifid_instr,
    input  ifid_pc,
    input  ifid_pc_plus4,
    input  ifid_irq,
    input  ifid_valid
  );
endinterface

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - combinational next-PC priority mux
// Purpose: picks the next PC from exception, branch, jr, jump, interrupt, stall
//          and sequential sources, highest first, and reports which one won.
// Ports:   pc                  current PC
//          exception/br_taken/jr/jump + targets   redirect requests
//          irq_take            qualified interrupt (already excludes redirects)
//          stall               hazard hold
//          next_pc, sel        chosen PC and its select code
module fetch_next_pc
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] IRQ_VEC = DEF_IRQ_VEC,
  parameter logic [31:0] EXC_VEC = DEF_EXC_VEC
) (
  input  logic [31:0] pc,
  input  logic        exception,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        irq_take,
  input  logic        stall,
  output logic [31:0] next_pc,
  output npc_sel_e    sel
);

  always_comb begin
    next_pc = pc_plus4(pc);
    sel     = SEL_SEQ;
    // Redirects sit above stall so a flushed slot is never held.
    if (exception) begin
      next_pc = EXC_VEC;
      sel     = SEL_EXC;
    end else if (br_taken) begin
      next_pc = br_target;
      sel     = SEL_BR;
    end else if (jr) begin
      next_pc = jr_target;
      sel     = SEL_JR;
    end else if (jump) begin
      next_pc = jump_target;
      sel     = SEL_JUMP;
    end else if (irq_take) begin
      next_pc = IRQ_VEC;
      sel     = SEL_IRQ;
    end else if (stall) begin
      next_pc = pc;
      sel     = SEL_HOLD;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - MIPS IF stage: PC register, imem address, IF/ID latch
// Purpose: owns the PC, drives instruction memory with it and registers the
//          returned word into the IF/ID latch; qualifies the timer interrupt.
// Ports:   clk, reset (sync, active-low)
//          stall                      hazard hold of PC and IF/ID
//          br_taken/br_target         EX branch redirect
//          jump/jump_target, jr/jr_target   ID redirects
//          exception                  ID undefined-opcode trap
//          irq                        level timer interrupt
//          bus (master)               imem_addr/imem_instr and ifid_* outputs
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] IRQ_VEC   = DEF_IRQ_VEC,
  parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exception,
  input  logic        irq,
  instruction_fetch_stage_if.master bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic        ifid_irq_q, ifid_irq_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        redirect;
  logic        irq_take;
  logic [31:0] next_pc;
  npc_sel_e    sel;

  assign redirect = exception | br_taken | jr | jump;

  // Interrupts are only taken in user mode, on a free-running cycle, and never
  // back-to-back with a bubble already in IF/ID; otherwise the level input is
  // simply looked at again next cycle.
  assign irq_take = irq & ~pc_q[31] & ~stall & ~redirect & ~ifid_irq_q;

  fetch_next_pc #(
    .IRQ_VEC (IRQ_VEC),
    .EXC_VEC (EXC_VEC)
  ) u_next_pc (
    .pc          (pc_q),
    .exception   (exception),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jr          (jr),
    .jr_target   (jr_target),
    .jump        (jump),
    .jump_target (jump_target),
    .irq_take    (irq_take),
    .stall       (stall),
    .next_pc     (next_pc),
    .sel         (sel)
  );

  always_comb begin
    pc_d            = pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_irq_d      = ifid_irq_q;
    ifid_valid_d    = ifid_valid_q;
    case (sel)
      SEL_EXC, SEL_BR, SEL_JR, SEL_JUMP: begin
        // Wrong-path fetch is squashed into a clean nop slot.
        pc_d            = next_pc;
        ifid_instr_d    = NOP_INSTR;
        ifid_pc_d       = 32'h0;
        ifid_pc_plus4_d = 32'h0;
        ifid_irq_d      = 1'b0;
        ifid_valid_d    = 1'b0;
      end
      SEL_IRQ: begin
        // The bubble carries the interrupted PC so ID can write it to $26.
        pc_d            = next_pc;
        ifid_instr_d    = NOP_INSTR;
        ifid_pc_d       = pc_q;
        ifid_pc_plus4_d = 32'h0;
        ifid_irq_d      = 1'b1;
        ifid_valid_d    = 1'b0;
      end
      SEL_SEQ: begin
        pc_d            = next_pc;
        ifid_instr_d    = bus.imem_instr;
        ifid_pc_d       = pc_q;
        ifid_pc_plus4_d = next_pc;
        ifid_irq_d      = 1'b0;
        ifid_valid_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q            <= RESET_VEC;
      ifid_instr_q    <= NOP_INSTR;
      ifid_pc_q       <= 32'h0;
      ifid_pc_plus4_q <= 32'h0;
      ifid_irq_q      <= 1'b0;
      ifid_valid_q    <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_irq_q      <= ifid_irq_d;
      ifid_valid_q    <= ifid_valid_d;
    end
  end

  assign bus.imem_addr     = pc_q;
  assign bus.ifid_instr    = ifid_instr_q;
  assign bus.ifid_pc       = ifid_pc_q;
  assign bus.ifid_pc_plus4 = ifid_pc_plus4_q;
  assign bus.ifid_irq      = ifid_irq_q;
  assign bus.ifid_valid    = ifid_valid_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - scoreboard bench for instruction_fetch_stage
module tb_instruction_fetch_stage;

  localparam logic [31:0] V_RESET = 32'h8000_0000;
  localparam logic [31:0] V_IRQ   = 32'h8000_0004;
  localparam logic [31:0] V_EXC   = 32'h8000_0008;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] p4;
    logic        irq;
    logic        valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_taken, jump, jr, exception, irq;
  logic [31:0] br_target, jump_target, jr_target;

  int compared = 0;
  int mismatched = 0;

  exp_t q[$];
  exp_t m;

  instruction_fetch_stage_if bus ();

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  assign bus.imem_instr = imem_word(bus.imem_addr);

  instruction_fetch_stage dut (
    .clk         (clk),
    .reset       (rst_n),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
    .jr          (jr),
    .jr_target   (jr_target),
    .exception   (exception),
    .irq         (irq),
    .bus         (bus)
  );

  task automatic idle();
    rst_n = 1'b1; stall = 1'b0; br_taken = 1'b0; jump = 1'b0; jr = 1'b0;
    exception = 1'b0; irq = 1'b0;
    br_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;
  endtask

  // Reference: architectural rules applied to the bench's own copy of the state.
  task automatic cycle();
    exp_t e;
    e = m;
    if (!rst_n) begin
      e = '{V_RESET, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    end else if (exception || br_taken || jr || jump) begin
      if (exception)     e.pc = V_EXC;
      else if (br_taken) e.pc = br_target;
      else if (jr)       e.pc = jr_target;
      else               e.pc = jump_target;
      e.instr = 0; e.ipc = 0; e.p4 = 0; e.irq = 0; e.valid = 0;
    end else if (irq && m.pc < 32'h8000_0000 && !stall && !m.irq) begin
      e = '{V_IRQ, 32'h0, m.pc, 32'h0, 1'b1, 1'b0};
    end else if (!stall) begin
      e.pc    = (m.pc & 32'h8000_0000) | ((m.pc + 32'd4) & 32'h7FFF_FFFF);
      e.instr = imem_word(m.pc);
      e.ipc   = m.pc;
      e.p4    = e.pc;
      e.irq   = 1'b0;
      e.valid = 1'b1;
    end
    q.push_back(e);
    m = e;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the DUT presents a new PC/IF/ID state after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("imem_addr",     bus.imem_addr,           e.pc);
        chk("ifid_instr",    bus.ifid_instr,          e.instr);
        chk("ifid_pc",       bus.ifid_pc,             e.ipc);
        chk("ifid_pc_plus4", bus.ifid_pc_plus4,       e.p4);
        chk("ifid_irq",      {31'h0, bus.ifid_irq},   {31'h0, e.irq});
        chk("ifid_valid",    {31'h0, bus.ifid_valid}, {31'h0, e.valid});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    m = '{32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    idle();
    // Reset then free run to 80000010.
    rst_n = 1'b0; cycle();
    rst_n = 1'b1;
    repeat (4) cycle();
    // Stall hold for two cycles, then release.
    stall = 1'b1; cycle(); cycle();
    stall = 1'b0; cycle();
    // Branch overrides stall.
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h8000_0040; cycle();
    idle(); cycle();
    // User-mode interrupt entry, no re-take in kernel, jr back, re-take.
    jr = 1'b1; jr_target = 32'h0000_0020; cycle();
    jr = 1'b0; irq = 1'b1; cycle();
    cycle(); cycle();
    jr = 1'b1; jr_target = 32'h0000_0020; cycle();
    jr = 1'b0; cycle();
    cycle();
    // Exception beats branch and interrupt.
    idle(); jr = 1'b1; jr_target = 32'h0000_0100; cycle();
    idle(); exception = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0200; irq = 1'b1; cycle();
    idle(); cycle();
    // User-space wrap at the top of the low half.
    jump = 1'b1; jump_target = 32'h7FFF_FFFC; cycle();
    idle(); cycle(); cycle();
    // Reset during stall with a pending jump.
    stall = 1'b1; jump = 1'b1; jump_target = 32'h0000_0400; rst_n = 1'b0; cycle();
    idle(); cycle();
    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      rst_n       = ($urandom % 64) != 0;
      stall       = ($urandom % 4) == 0;
      br_taken    = ($urandom % 10) == 0;
      jump        = ($urandom % 10) == 0;
      jr          = ($urandom % 12) == 0;
      exception   = ($urandom % 25) == 0;
      irq         = ($urandom % 3) == 0;
      br_target   = $urandom & 32'hFFFF_FFFC;
      jump_target = $urandom & 32'hFFFF_FFFC;
      jr_target   = ($urandom & 32'h7FFF_FFFC) | (($urandom % 4 == 0) ? 32'h8000_0000 : 32'h0);
      cycle();
    end
    idle(); cycle(); cycle();
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
